pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Fetch-side sequencer owning the architectural fetch PC. Advances the PC sequentially under the fetch handshake, accepts resolved branches from execute, computes the taken target (PC-relative or register-relative), redirects fetch, and squashes younger in-flight instructions for a fixed number of cycles. Sits between the execute-stage branch unit and the instruction-fetch stage.

## Interface
- WordSize, 32, datapath/PC width
- ResetVector, 32'h0000_0000, first fetch address after reset
- FlushCycles, 2, younger stages squashed per redirect (1..7)

- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- stall_in  in  1  hazard stall; freezes sequential advance only
- branch_valid  in  1  execute presents a resolved branch/jump this cycle
- branch_taken  in  1  resolution; qualified by branch_valid
- addr_mode  in  1  0 = PC-relative (br_pc+imm), 1 = register-relative (rs1d+imm)
- imm, rs1d, br_pc  in  WordSize  offset, base register, PC of the branch
- imem_ready  in  1  fetch accepts pc_out this cycle
- pc_out  out  WordSize  fetch address
- fetch_valid  out  1  pc_out is a valid request
- flush  out  1  squash all stages younger than execute
- misalign_trap  out  1  one-cycle misaligned-target pulse (see Configuration)

## Operation
- States: BOOT, RUN, FLUSH.
- Reset (async): state=BOOT, pc_out=ResetVector, fetch_valid=0, flush=0, misalign_trap=0, flush counter=0.
- BOOT: one cycle after rstn deasserts, go to RUN; no outputs change except fetch_valid→1 on entering RUN.
- RUN: fetch_valid=1. Accept = fetch_valid & imem_ready & !stall_in; on accept pc_out ← pc_out+4.
- Redirect (RUN only): branch_valid & branch_taken. Target = br_pc+imm (mode 0) or (rs1d+imm) with bit0 cleared (mode 1). Next cycle: pc_out ← target, flush=1, fetch_valid=0, counter ← FlushCycles, state=FLUSH. Redirect overrides accept and stall.
- Not-taken or branch_valid=0: no effect.
- FLUSH: flush=1, fetch_valid=0, counter decrements each cycle; at counter==1 next state RUN (flush→0, fetch_valid→1). branch_valid ignored (squashed producers). stall_in does not extend FLUSH.
- Arithmetic: all adds modulo 2^WordSize; 32'hFFFF_FFFC+4 wraps to 0; negative imm via two's complement.
- Reset asserted mid-FLUSH: immediate return to BOOT values; pending redirect discarded.

## Timing
- Taken branch at cycle N → pc_out=target and flush=1 at N+1; flush high N+1..N+FlushCycles; fetch_valid=1 at N+FlushCycles+1.
- Sequential accept at N → pc_out+4 visible at N+1.
- imem_ready=0 or stall_in=1 in RUN: pc_out holds, fetch_valid stays 1.
- All outputs registered; no combinational input→output path.

## Configuration
- PC_REDIRECT_MISALIGN_TRAP_EN defined: if target[1:0]≠0 on a taken redirect, pc_out is NOT updated, misalign_trap=1 at N+1 only, FLUSH sequence proceeds identically.
- Undefined: target used unchanged (bit0 clear in mode 1 only); misalign_trap tied 0.

## Structure
- Package branch_pkg: addr_mode_e (ADDR_PC=0, ADDR_RD=1), redirect_state_e (BOOT, RUN, FLUSH), PC_STEP=4.
- Sub-module branch_target_calc: combinational target mux/adder (addr_mode, imm, rs1d, br_pc → target); FSM, PC register, counter in top.

## Test plan
- Reset: rstn low → pc_out=0, fetch_valid=0, flush=0; release → fetch_valid=1 after BOOT cycle; imem_ready=1 gives 0,4,8,C on consecutive cycles.
- Stall/handshake: imem_ready=0 for 3 cycles at pc_out=0x10 → holds 0x10, then 0x14; stall_in=1 likewise holds.
- PC-relative taken: br_pc=0x100, imm=-8 at N → pc_out=0xF8 at N+1, flush N+1..N+2, fetch_valid=1 at N+3; branch_valid during FLUSH ignored.
- Register-relative: rs1d=0x2001, imm=0x4, mode 1 → pc_out=0x2004; not-taken branch → sequential advance unaffected.
- Wrap and priority: pc_out=0xFFFF_FFFC accepted → 0x0; taken branch with stall_in=1 and imem_ready=1 same cycle → redirect wins.
- Macro on: target 0x102 → misalign_trap pulse at N+1, pc_out unchanged, flush 2 cycles; macro off → pc_out=0x102, trap 0. Reset mid-FLUSH → pc_out=ResetVector, flush=0 immediately.

Source files
------------

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch-side PC redirect controller.
package branch_pkg;

  typedef enum logic {
    ADDR_PC = 1'b0,
    ADDR_RD = 1'b1
  } addr_mode_e;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } redirect_state_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Branch-resolution and fetch-request bundle between execute, fetch and the PC redirect controller.
interface pc_redirect_ctrl_if #(
  parameter int WordSize = 32
);

  logic                stall_in;
  logic                branch_valid;
  logic                branch_taken;
  logic                addr_mode;
  logic [WordSize-1:0] imm;
  logic [WordSize-1:0] rs1d;
  logic [WordSize-1:0] br_pc;
  logic                imem_ready;
  logic [WordSize-1:0] pc_out;
  logic                fetch_valid;
  logic                flush;
  logic                misalign_trap;

  modport master (
    output stall_in, branch_valid, branch_taken, addr_mode, imm, rs1d, br_pc, imem_ready,
    input  pc_out, fetch_valid, flush, misalign_trap
  );

  modport slave (
    input  stall_in, branch_valid, branch_taken, addr_mode, imm, rs1d, br_pc, imem_ready,
    output pc_out, fetch_valid, flush, misalign_trap
  );

endinterface

// File: rtl/pc_redirect_ctrl_target.sv
// Combinational branch target: PC-relative or register-relative (bit0 cleared) add.
module branch_target_calc
  import branch_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  addr_mode_e          addr_mode_i,
  input  logic [WordSize-1:0] imm_i,
  input  logic [WordSize-1:0] rs1d_i,
  input  logic [WordSize-1:0] br_pc_i,
  output logic [WordSize-1:0] target_o
);

  logic [WordSize-1:0] base;
  logic [WordSize-1:0] sum;

  always_comb begin
    base     = (addr_mode_i == ADDR_RD) ? rs1d_i : br_pc_i;
    sum      = base + imm_i;
    target_o = sum;
    if (addr_mode_i == ADDR_RD) begin
      target_o[0] = 1'b0;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: sequential advance, taken-branch redirect and fixed-length younger-stage flush.
// Optional misaligned-target trap enabled by defining PC_REDIRECT_MISALIGN_TRAP_EN.
module pc_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int                   WordSize    = 32,
  parameter logic [WordSize-1:0]  ResetVector = '0,
  parameter int                   FlushCycles = 2
) (
  input  logic             clk,
  input  logic             rstn,
  pc_redirect_ctrl_if.slave bus
);

  localparam logic [WordSize-1:0] Step     = WordSize'(PC_STEP);
  localparam logic [2:0]          FlushLen = 3'(FlushCycles);

  redirect_state_e     state_q, state_d;
  logic [WordSize-1:0] pc_q, pc_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                flush_q, flush_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [WordSize-1:0] target;
  logic                redirect;
  logic                accept;
  logic                misaligned;
  logic                trap_d;

  branch_target_calc #(.WordSize(WordSize)) u_target (
    .addr_mode_i (addr_mode_e'(bus.addr_mode)),
    .imm_i       (bus.imm),
    .rs1d_i      (bus.rs1d),
    .br_pc_i     (bus.br_pc),
    .target_o    (target)
  );

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
  assign misaligned = (target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign redirect = bus.branch_valid & bus.branch_taken;
  assign accept   = fetch_valid_q & bus.imem_ready & ~bus.stall_in;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = flush_q;
    cnt_d         = cnt_q;
    trap_d        = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        // A taken redirect beats both the sequential accept and any stall.
        if (redirect) begin
          if (misaligned) begin
            trap_d = 1'b1;
          end else begin
            pc_d = target;
          end
          state_d       = FLUSH;
          flush_d       = 1'b1;
          fetch_valid_d = 1'b0;
          cnt_d         = FlushLen;
        end else if (accept) begin
          pc_d = pc_q + Step;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d       = RUN;
          flush_d       = 1'b0;
          fetch_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= BOOT;
      pc_q          <= ResetVector;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      cnt_q         <= 3'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      cnt_q         <= cnt_d;
    end
  end

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign bus.misalign_trap = trap_q;
`else
  assign bus.misalign_trap = 1'b0;
`endif

  assign bus.pc_out      = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed vector table, reset-mid-flush sequence,
// then randomized traffic against a cycle-level behavioural model.
module tb_pc_redirect_ctrl;

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif
  localparam int FlushN = 2;

  typedef struct {
    logic        stall;
    logic        bv;
    logic        bt;
    logic        mode;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic [31:0] brpc;
    logic        ready;
    logic [31:0] expPc;
    logic        expFv;
    logic        expFlush;
    logic        expTrap;
  } vec_t;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  // Behavioural model: boot pending flag, flush cycles still to show, PC and one-shot trap.
  bit          mBoot;
  int          mFlushLeft;
  logic [31:0] mPc;
  bit          mTrap;

  vec_t vecs[27];

  pc_redirect_ctrl_if #(.WordSize(32)) bus ();

  pc_redirect_ctrl #(
    .WordSize    (32),
    .ResetVector (32'h0000_0000),
    .FlushCycles (FlushN)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic stall, logic bv, logic bt, logic mode, logic [31:0] imm,
                              logic [31:0] rs1d, logic [31:0] brpc, logic ready,
                              logic [31:0] expPc, logic expFv, logic expFlush, logic expTrap);
    vec_t v;
    v.stall = stall; v.bv = bv; v.bt = bt; v.mode = mode;
    v.imm = imm; v.rs1d = rs1d; v.brpc = brpc; v.ready = ready;
    v.expPc = expPc; v.expFv = expFv; v.expFlush = expFlush; v.expTrap = expTrap;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.stall_in     = v.stall;
    bus.branch_valid = v.bv;
    bus.branch_taken = v.bt;
    bus.addr_mode    = v.mode;
    bus.imm          = v.imm;
    bus.rs1d         = v.rs1d;
    bus.br_pc        = v.brpc;
    bus.imem_ready   = v.ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expPc, input logic expFv,
                             input logic expFlush, input logic expTrap);
    checks++;
    if (bus.pc_out !== expPc) begin
      failures++;
      $display("[TB] FAIL %s pc_out: got %h expected %h", name, bus.pc_out, expPc);
    end
    checks++;
    if (bus.fetch_valid !== expFv) begin
      failures++;
      $display("[TB] FAIL %s fetch_valid: got %b expected %b", name, bus.fetch_valid, expFv);
    end
    checks++;
    if (bus.flush !== expFlush) begin
      failures++;
      $display("[TB] FAIL %s flush: got %b expected %b", name, bus.flush, expFlush);
    end
    checks++;
    if (bus.misalign_trap !== expTrap) begin
      failures++;
      $display("[TB] FAIL %s misalign_trap: got %b expected %b", name, bus.misalign_trap, expTrap);
    end
  endtask

  // Advance the model by one clock given the inputs presented this cycle.
  task automatic modelStep(input vec_t v);
    logic [31:0] tgt;
    mTrap = 1'b0;
    if (mBoot) begin
      mBoot = 1'b0;
    end else if (mFlushLeft > 0) begin
      mFlushLeft--;
    end else if (v.bv && v.bt) begin
      tgt = v.mode ? ((v.rs1d + v.imm) & ~32'd1) : (v.brpc + v.imm);
      if (TrapEn && (tgt % 4 != 0)) mTrap = 1'b1;
      else mPc = tgt;
      mFlushLeft = FlushN;
    end else if (v.ready && !v.stall) begin
      mPc = mPc + 32'd4;
    end
  endtask

  initial begin
    vec_t        r;
    logic [31:0] misPc;
    checks   = 0;
    failures = 0;
    misPc    = TrapEn ? 32'h0 : 32'h102;

    vecs[0]  = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'h0,         1,0,0);
    vecs[1]  = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'h4,         1,0,0);
    vecs[2]  = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'h8,         1,0,0);
    vecs[3]  = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'hC,         1,0,0);
    vecs[4]  = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'h10,        1,0,0);
    vecs[5]  = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         0, 32'h10,        1,0,0);
    vecs[6]  = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         0, 32'h10,        1,0,0);
    vecs[7]  = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         0, 32'h10,        1,0,0);
    vecs[8]  = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'h14,        1,0,0);
    vecs[9]  = mk(1,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'h14,        1,0,0);
    vecs[10] = mk(1,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'h14,        1,0,0);
    vecs[11] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'h18,        1,0,0);
    vecs[12] = mk(0,1,1,0, 32'hFFFF_FFF8,32'h0,    32'h100,       1, 32'hF8,        0,1,0);
    vecs[13] = mk(0,1,1,0, 32'h0,        32'h0,    32'h500,       1, 32'hF8,        0,1,0);
    vecs[14] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'hF8,        1,0,0);
    vecs[15] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'hFC,        1,0,0);
    vecs[16] = mk(0,1,0,0, 32'h0,        32'h0,    32'h40,        1, 32'h100,       1,0,0);
    vecs[17] = mk(0,1,1,1, 32'h4,        32'h2001, 32'h0,         1, 32'h2004,      0,1,0);
    vecs[18] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         0, 32'h2004,      0,1,0);
    vecs[19] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         0, 32'h2004,      1,0,0);
    vecs[20] = mk(1,1,1,0, 32'hC,        32'h0,    32'hFFFF_FFF0, 1, 32'hFFFF_FFFC, 0,1,0);
    vecs[21] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'hFFFF_FFFC, 0,1,0);
    vecs[22] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'hFFFF_FFFC, 1,0,0);
    vecs[23] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, 32'h0,         1,0,0);
    vecs[24] = mk(0,1,1,0, 32'h2,        32'h0,    32'h100,       1, misPc,         0,1,TrapEn);
    vecs[25] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         1, misPc,         0,1,0);
    vecs[26] = mk(0,0,0,0, 32'h0,        32'h0,    32'h0,         0, misPc,         1,0,0);

    rstn = 1'b0;
    applyStimulus(mk(0,0,0,0, 32'h0,32'h0,32'h0,0, 32'h0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;

    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expFv, vecs[i].expFlush,
                  vecs[i].expTrap);
    end

    // Reset asserted while flushing must clear everything immediately.
    applyStimulus(mk(0,1,1,0, 32'h0,32'h0,32'h300,1, 32'h0,0,0,0));
    @(posedge clk);
    #1;
    checkOutput("redirect_before_reset", 32'h300, 1'b0, 1'b1, 1'b0);
    applyStimulus(mk(0,0,0,0, 32'h0,32'h0,32'h0,1, 32'h0,0,0,0));
    rstn = 1'b0;
    #2;
    checkOutput("reset_mid_flush", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 32'h0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;

    mBoot      = 1'b1;
    mFlushLeft = 0;
    mPc        = 32'h0;
    mTrap      = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r.stall = ($urandom_range(0, 3) == 0);
      r.ready = ($urandom_range(0, 3) != 0);
      r.bv    = ($urandom_range(0, 4) == 0);
      r.bt    = $urandom_range(0, 1) == 1;
      r.mode  = $urandom_range(0, 1) == 1;
      r.rs1d  = $urandom;
      r.brpc  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) r.imm = $urandom;
      else r.imm = (32'($urandom_range(0, 511)) - 32'd256) & 32'hFFFF_FFFC;
      applyStimulus(r);
      modelStep(r);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rand%0d", i), mPc, (!mBoot && mFlushLeft == 0), (mFlushLeft > 0),
                  mTrap);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
